// File: rtl/multi_blink_gen.sv
// ---------------------------------------------------------------------------
// multi_blink_gen
//   Multi-channel LED pattern generator. Each of NUM_CH channels has its own
//   run-time mode (OFF / ON / BLINK / ONESHOT) and on/off phase lengths,
//   programmed through a valid/ready configuration write port.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   cfg_valid  in   1        configuration write request
//   cfg_ready  out  1        configuration port can accept (1 after reset)
//   cfg_ch     in   CH_W     target channel index
//   cfg_mode   in   2        00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
//   cfg_on     in   CNT_W    on-phase length in clk cycles (0 acts as 1)
//   cfg_off    in   CNT_W    off-phase length in clk cycles (0 acts as 1)
//   cfg_err    out  1        one-cycle pulse: write accepted to a missing channel
//   led        out  NUM_CH   LED drive, 1 = lit
//   done       out  NUM_CH   one-cycle pulse when a ONESHOT completes
// ---------------------------------------------------------------------------
module multi_blink_gen #(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 27,
  parameter  int DEF_ON  = 50000000,
  parameter  int DEF_OFF = 25000000,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_on,
  input  logic [CNT_W-1:0]  cfg_off,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] done
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] ON_RST  = CNT_W'(DEF_ON);
  localparam logic [CNT_W-1:0] OFF_RST = CNT_W'(DEF_OFF);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Shared configuration-port control
  logic cfg_ready_q;
  logic cfg_err_q;
  logic wr_acc;
  logic ch_bad;

  assign wr_acc = cfg_valid & cfg_ready_q;
  // Widen both sides so the check still works when NUM_CH is not a power of two.
  assign ch_bad = (32'(cfg_ch) >= 32'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= wr_acc & ch_bad;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

  // Per-channel pattern engine
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             sel;
    logic [CNT_W-1:0] phase_len;
    logic [CNT_W-1:0] last;
    logic             at_end;

    assign sel = wr_acc & ~ch_bad & (cfg_ch == CH_W'(i));

    // Only a BLINK channel in its dark phase uses the off time; a ONESHOT is
    // always in its on phase while running.
    assign phase_len = (mode_q == MODE_BLINK && !led_q) ? off_q : on_q;
    // A zero-length phase behaves as a one-cycle phase.
    assign last      = (phase_len == '0) ? '0 : (phase_len - ONE);
    assign at_end    = (cnt_q == last);

    always_comb begin
      mode_d = mode_q;
      on_d   = on_q;
      off_d  = off_q;
      cnt_d  = cnt_q;
      led_d  = led_q;
      done_d = 1'b0;
      if (sel) begin
        // A write overrides any phase boundary in the same cycle, so an
        // aborted ONESHOT never produces a done pulse.
        mode_d = mode_e'(cfg_mode);
        on_d   = cfg_on;
        off_d  = cfg_off;
        cnt_d  = '0;
        led_d  = (mode_e'(cfg_mode) != MODE_OFF);
      end else begin
        case (mode_q)
          MODE_OFF: begin
            cnt_d = '0;
            led_d = 1'b0;
          end
          MODE_ON: begin
            cnt_d = '0;
            led_d = 1'b1;
          end
          MODE_BLINK: begin
            if (at_end) begin
              cnt_d = '0;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          MODE_ONESHOT: begin
            if (at_end) begin
              cnt_d  = '0;
              led_d  = 1'b0;
              mode_d = MODE_OFF;
              done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          default: begin
            cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q <= MODE_BLINK;
        on_q   <= ON_RST;
        off_q  <= OFF_RST;
        cnt_q  <= '0;
        led_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        mode_q <= mode_d;
        on_q   <= on_d;
        off_q  <= off_d;
        cnt_q  <= cnt_d;
        led_q  <= led_d;
        done_q <= done_d;
      end
    end

    assign led[i]  = led_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_multi_blink_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_blink_gen
//   Directed bench for multi_blink_gen (CNT_W=8, DEF_ON=4, DEF_OFF=2).
//   u_dut has NUM_CH=2. A second instance u_dut3 has NUM_CH=3 so that
//   cfg_ch=3 is representable and exercises the invalid-channel path.
//   k counts rising edges since the most recent reset release; an untouched
//   channel shows led = ((k % 6) >= 2).
// ---------------------------------------------------------------------------
module tb_multi_blink_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_on;
  logic [7:0] cfg_off;
  logic       cfg_err;
  logic [1:0] led;
  logic [1:0] done;

  logic       cfg_valid3;
  logic       cfg_ready3;
  logic [1:0] cfg_ch3;
  logic       cfg_err3;
  logic [2:0] led3;
  logic [2:0] done3;

  multi_blink_gen #(.NUM_CH(2), .CNT_W(8), .DEF_ON(4), .DEF_OFF(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_on    (cfg_on),
    .cfg_off   (cfg_off),
    .cfg_err   (cfg_err),
    .led       (led),
    .done      (done)
  );

  multi_blink_gen #(.NUM_CH(3), .CNT_W(8), .DEF_ON(4), .DEF_OFF(2)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_mode  (cfg_mode),
    .cfg_on    (cfg_on),
    .cfg_off   (cfg_off),
    .cfg_err   (cfg_err3),
    .led       (led3),
    .done      (done3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic wr(input logic [0:0] ch, input logic [1:0] mode,
                    input logic [7:0] on_t, input logic [7:0] off_t);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_on    = on_t;
    cfg_off   = off_t;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Default-pattern check after a reset release; called with k=0.
  task automatic idle_seq(input string pfx);
    for (int i = 0; i < 12; i++) begin
      chk({pfx, "_led0"},  32'(led[0]), 32'((k % 6) >= 2));
      chk({pfx, "_led1"},  32'(led[1]), 32'((k % 6) >= 2));
      chk({pfx, "_led3"},  32'(led3),   32'(((k % 6) >= 2) ? 3'b111 : 3'b000));
      chk({pfx, "_ready"}, 32'(cfg_ready), 32'(k >= 1));
      chk({pfx, "_done"},  32'(done),   32'd0);
      chk({pfx, "_err"},   32'(cfg_err), 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_valid3 = 1'b0;
    cfg_ch     = '0;
    cfg_ch3    = '0;
    cfg_mode   = 2'b00;
    cfg_on     = '0;
    cfg_off    = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_led",    32'(led),        32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_ready",  32'(cfg_ready),  32'd0);
    chk("rst_err",    32'(cfg_err),    32'd0);
    chk("rst_led3",   32'(led3),       32'd0);
    chk("rst_ready3", 32'(cfg_ready3), 32'd0);

    // 1: release and idle blink (low 2, high 4, ...)
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    idle_seq("idle");

    // 2: ch1 ONESHOT on=3, accepted at edge 13; led1 high k=13..15, done at 16
    wr(1'b1, 2'b11, 8'd3, 8'd0);
    while (k <= 20) begin
      chk("os_led1",  32'(led[1]),  32'(k <= 15));
      chk("os_done1", 32'(done[1]), 32'(k == 16));
      chk("os_done0", 32'(done[0]), 32'd0);
      chk("os_led0",  32'(led[0]),  32'((k % 6) >= 2));
      tick();
    end

    // 3: ch0 BLINK on=0 off=0, accepted at edge 22; toggles every cycle
    wr(1'b0, 2'b10, 8'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      chk("fast_led0", 32'(led[0]), 32'(((k - 22) % 2) == 0));
      chk("fast_led1", 32'(led[1]), 32'd0);
      chk("fast_done", 32'(done),   32'd0);
      tick();
    end

    // 4: invalid channel on the 3-channel instance
    chk("err3_pre", 32'(cfg_err3), 32'd0);
    cfg_valid3 = 1'b1;
    cfg_ch3    = 2'd3;
    cfg_mode   = 2'b01;
    cfg_on     = 8'd5;
    cfg_off    = 8'd5;
    tick();
    cfg_valid3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("err3_pulse", 32'(cfg_err3), 32'(i == 0));
      chk("err3_led",   32'(led3),     32'(((k % 6) >= 2) ? 3'b111 : 3'b000));
      chk("err3_done",  32'(done3),    32'd0);
      chk("err_main",   32'(cfg_err),  32'd0);
      chk("err_led0",   32'(led[0]),   32'(((k - 22) % 2) == 0));
      tick();
    end

    // 5: ch0 BLINK on=3, then ON written on the edge where led0 would fall
    wr(1'b0, 2'b10, 8'd3, 8'd2);
    chk("wins_on0", 32'(led[0]), 32'd1);
    tick();
    chk("wins_on1", 32'(led[0]), 32'd1);
    tick();
    chk("wins_on2", 32'(led[0]), 32'd1);
    wr(1'b0, 2'b01, 8'd3, 8'd2);
    for (int i = 0; i < 4; i++) begin
      chk("wins_hold", 32'(led[0]), 32'd1);
      chk("wins_done", 32'(done),   32'd0);
      tick();
    end

    // 6: asynchronous reset between clock edges while ch0 is lit
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_led",    32'(led),        32'd0);
    chk("arst_ready",  32'(cfg_ready),  32'd0);
    chk("arst_led3",   32'(led3),       32'd0);
    chk("arst_ready3", 32'(cfg_ready3), 32'd0);
    chk("arst_done",   32'(done),       32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    idle_seq("again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
